// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store responder: drives a synchronous word-wide data RAM with
// RAM_LATENCY-cycle read latency and holds the pipeline while a load is in flight.
//
// state  | meaning
// S_IDLE | accept request; writes complete here, aligned reads are issued here
// S_WAIT | read outstanding, counting down RAM latency, stall held high
// S_DONE | load data valid, stall released, held instruction must not re-issue
module data_mem_access_unit #(
   parameter int ISA_WIDTH   = 32,
   parameter int ADDR_WIDTH  = 14,
   parameter int RAM_LATENCY = 2   // legal range 1..7 (3-bit countdown)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_no_op,
   input  logic [1:0]            mem_mem_control,
   input  logic [ISA_WIDTH-1:0]  mem_alu_result,
   input  logic [ISA_WIDTH-1:0]  mem_store_data,
   output logic [ISA_WIDTH-1:0]  mem_read_data,
   output logic                  mem_stall_req,
   output logic                  mem_misalign,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [ISA_WIDTH-1:0]  ram_wdata,
   input  logic [ISA_WIDTH-1:0]  ram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] LP_CNT_INIT = 3'(RAM_LATENCY - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [2:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ISA_WIDTH-1:0]  r_read_data;

   logic                  w_valid;
   logic                  w_aligned;
   logic                  w_is_write;
   logic                  w_issue_rd;
   logic [ADDR_WIDTH-1:0] w_word;
   logic                  w_unused_addr_hi;

   assign w_valid    = ~mem_no_op & (mem_mem_control[1] | mem_mem_control[0]);
   assign w_aligned  = (mem_alu_result[1:0] == 2'b00);
   // Both control bits set is a write; the read bit is then ignored.
   assign w_is_write = mem_mem_control[1];
   assign w_word     = mem_alu_result[ADDR_WIDTH+1:2];
   assign w_issue_rd = (r_state == S_IDLE) & w_valid & w_aligned & ~w_is_write;

   // Address bits above the RAM word index wrap and are intentionally dropped.
   assign w_unused_addr_hi = ^mem_alu_result[ISA_WIDTH-1:ADDR_WIDTH+2];

   always_comb begin
      w_state_nxt   = r_state;
      ram_en        = 1'b0;
      ram_we        = 1'b0;
      ram_addr      = w_word;
      ram_wdata     = mem_store_data;
      mem_stall_req = 1'b0;
      mem_misalign  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_valid) begin
               if (!w_aligned) begin
                  mem_misalign = 1'b1;
               end else if (w_is_write) begin
                  ram_en = 1'b1;
                  ram_we = 1'b1;
               end else begin
                  ram_en        = 1'b1;
                  mem_stall_req = 1'b1;
                  w_state_nxt   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            ram_addr      = r_addr;
            mem_stall_req = 1'b1;
            if (r_cnt == 3'd0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Outputs are forced low for as long as reset is asserted, not just at the next edge.
      if (!rst_n) begin
         ram_en        = 1'b0;
         ram_we        = 1'b0;
         ram_addr      = '0;
         ram_wdata     = '0;
         mem_stall_req = 1'b0;
         mem_misalign  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_addr      <= '0;
         r_read_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue_rd) begin
            r_addr <= w_word;
            r_cnt  <= LP_CNT_INIT;
         end else if (r_state == S_WAIT) begin
            if (r_cnt != 3'd0) begin
               r_cnt <= r_cnt - 3'd1;
            end else begin
               r_read_data <= ram_rdata;
            end
         end
      end
   end

   assign mem_read_data = r_read_data;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: three instances (RAM latency 1, 2, 7), each with its
// own RAM model and a cycle-numbered reference model of load/store timing.
module tb_data_mem_access_unit;

   localparam int NCYC  = 1500;
   localparam int DEPTH = 16384;

   typedef struct {
      logic        nop;
      logic [1:0]  ctl;
      logic [31:0] a;
      logic [31:0] d;
   } instr_t;

   logic        clk;
   logic        rst_n;
   logic        i_nop   [3];
   logic [1:0]  i_ctl   [3];
   logic [31:0] i_alu   [3];
   logic [31:0] i_sd    [3];
   logic [31:0] o_rd    [3];
   logic        o_stall [3];
   logic        o_mis   [3];
   logic        o_en    [3];
   logic        o_we    [3];
   logic [13:0] o_addr  [3];
   logic [31:0] o_wdata [3];
   logic [31:0] ram_rd  [3];

   int n_cmp;
   int n_err;

   instr_t      q [3][$];
   int          done_c   [3];
   int          lat_addr [3];
   logic [31:0] rd_old   [3];
   logic [31:0] pend     [3];
   bit          adv      [3];
   logic [31:0] ref_mem  [3][DEPTH];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LG = (g == 0) ? 1 : ((g == 1) ? 2 : 7);
      logic [31:0] mem  [DEPTH];
      logic [31:0] pipe [7];

      data_mem_access_unit #(
         .ISA_WIDTH  (32),
         .ADDR_WIDTH (14),
         .RAM_LATENCY(LG)
      ) u_dut (
         .clk            (clk),
         .rst_n          (rst_n),
         .mem_no_op      (i_nop[g]),
         .mem_mem_control(i_ctl[g]),
         .mem_alu_result (i_alu[g]),
         .mem_store_data (i_sd[g]),
         .mem_read_data  (o_rd[g]),
         .mem_stall_req  (o_stall[g]),
         .mem_misalign   (o_mis[g]),
         .ram_en         (o_en[g]),
         .ram_we         (o_we[g]),
         .ram_addr       (o_addr[g]),
         .ram_wdata      (o_wdata[g]),
         .ram_rdata      (ram_rd[g])
      );

      assign ram_rd[g] = pipe[LG-1];

      // Read data emerges LG edges after the strobe; other slots carry junk.
      always @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         end else if (o_en[g] && o_we[g]) begin
            mem[o_addr[g]] <= o_wdata[g];
         end
         pipe[0] <= (o_en[g] && !o_we[g]) ? mem[o_addr[g]] : $urandom;
         for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
      end
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 2 : 7);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic instr_t rnd_instr();
      instr_t t;
      int     r;
      t.nop = ($urandom_range(0, 7) == 0);
      t.ctl = 2'($urandom_range(0, 3));
      t.a   = 32'($urandom_range(0, 31)) << 2;
      r     = $urandom_range(0, 9);
      if (r == 0)      t.a = t.a | 32'($urandom_range(1, 3));
      else if (r == 1) t.a = t.a | ($urandom << 16);
      t.d = $urandom;
      return t;
   endfunction

   task automatic push_all(input logic nop, input logic [1:0] ctl, input logic [31:0] a,
                           input logic [31:0] d);
      instr_t t;
      t.nop = nop; t.ctl = ctl; t.a = a; t.d = d;
      for (int k = 0; k < 3; k++) q[k].push_back(t);
   endtask

   task automatic eval(input int k, input int c);
      string p;
      int    w;
      logic  valid, e_en, e_we, e_stall, e_mis;
      p = $sformatf("L%0d_c%0d", lat_of(k), c);
      if (!rst_n) begin
         done_c[k] = -1;
         rd_old[k] = '0;
         adv[k]    = 1'b0;
         for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = '0;
         chk({p, "_rst_en"},    32'(o_en[k]),    32'd0);
         chk({p, "_rst_stall"}, 32'(o_stall[k]), 32'd0);
         chk({p, "_rst_mis"},   32'(o_mis[k]),   32'd0);
         chk({p, "_rst_addr"},  32'(o_addr[k]),  32'd0);
         chk({p, "_rst_wdata"}, o_wdata[k],      32'd0);
         chk({p, "_rst_rdata"}, o_rd[k],         32'd0);
         return;
      end
      adv[k] = 1'b1;
      if (c < done_c[k]) begin
         adv[k] = 1'b0;
         chk({p, "_wait_en"},    32'(o_en[k]),    32'd0);
         chk({p, "_wait_we"},    32'(o_we[k]),    32'd0);
         chk({p, "_wait_stall"}, 32'(o_stall[k]), 32'd1);
         chk({p, "_wait_mis"},   32'(o_mis[k]),   32'd0);
         chk({p, "_wait_addr"},  32'(o_addr[k]),  32'(lat_addr[k]));
         chk({p, "_wait_rdata"}, o_rd[k],         rd_old[k]);
      end else if (c == done_c[k]) begin
         rd_old[k] = pend[k];
         chk({p, "_done_en"},    32'(o_en[k]),    32'd0);
         chk({p, "_done_stall"}, 32'(o_stall[k]), 32'd0);
         chk({p, "_done_mis"},   32'(o_mis[k]),   32'd0);
         chk({p, "_done_rdata"}, o_rd[k],         rd_old[k]);
      end else begin
         valid   = !i_nop[k] && (i_ctl[k] != 2'b00);
         w       = int'((i_alu[k] >> 2) % DEPTH);
         e_en    = 1'b0;
         e_we    = 1'b0;
         e_stall = 1'b0;
         e_mis   = 1'b0;
         if (valid) begin
            if (i_alu[k] % 4 != 0) begin
               e_mis = 1'b1;
            end else if (i_ctl[k] == 2'b10 || i_ctl[k] == 2'b11) begin
               e_en = 1'b1;
               e_we = 1'b1;
               ref_mem[k][w] = i_sd[k];
            end else begin
               e_en        = 1'b1;
               e_stall     = 1'b1;
               pend[k]     = ref_mem[k][w];
               lat_addr[k] = w;
               done_c[k]   = c + lat_of(k) + 1;
               adv[k]      = 1'b0;
            end
         end
         chk({p, "_en"},    32'(o_en[k]),    32'(e_en));
         chk({p, "_we"},    32'(o_we[k]),    32'(e_we));
         chk({p, "_stall"}, 32'(o_stall[k]), 32'(e_stall));
         chk({p, "_mis"},   32'(o_mis[k]),   32'(e_mis));
         chk({p, "_addr"},  32'(o_addr[k]),  32'(w));
         chk({p, "_wdata"}, o_wdata[k],      i_sd[k]);
         chk({p, "_rdata"}, o_rd[k],         rd_old[k]);
      end
   endtask

   initial begin
      instr_t t;
      int     rst_rel;
      bit     did_async;
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      rst_rel   = 3;
      did_async = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_nop[k]    = 1'b1;
         i_ctl[k]    = 2'b00;
         i_alu[k]    = '0;
         i_sd[k]     = '0;
         done_c[k]   = -1;
         lat_addr[k] = 0;
         rd_old[k]   = '0;
         pend[k]     = '0;
         adv[k]      = 1'b0;
      end

      push_all(1'b0, 2'b10, 32'h10,      32'hDEADBEEF);
      push_all(1'b0, 2'b01, 32'h10,      32'h0);
      push_all(1'b0, 2'b01, 32'h12,      32'h0);
      push_all(1'b0, 2'b11, 32'h20,      32'h5);
      push_all(1'b0, 2'b01, 32'h20,      32'h0);
      push_all(1'b1, 2'b01, 32'h20,      32'h0);
      push_all(1'b0, 2'b10, 32'h4,       32'h12345678);
      push_all(1'b0, 2'b01, 32'h0,       32'h0);
      push_all(1'b0, 2'b01, 32'h4,       32'h0);
      push_all(1'b0, 2'b01, 32'h0010_0010, 32'h0);

      @(posedge clk);
      #1;
      for (int c = 0; c < NCYC; c++) begin
         if (c == rst_rel) rst_n = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (adv[k]) begin
               t = (q[k].size() != 0) ? q[k].pop_front() : rnd_instr();
               i_nop[k] = t.nop;
               i_ctl[k] = t.ctl;
               i_alu[k] = t.a;
               i_sd[k]  = t.d;
            end
         end
         if (!did_async && c >= 1000 && rst_n && c < done_c[2]) begin
            #2;
            rst_n = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
               chk($sformatf("L%0d_async_stall", lat_of(k)), 32'(o_stall[k]), 32'd0);
               chk($sformatf("L%0d_async_rdata", lat_of(k)), o_rd[k],         32'd0);
               chk($sformatf("L%0d_async_en",    lat_of(k)), 32'(o_en[k]),    32'd0);
            end
            rst_rel   = c + 3;
            did_async = 1'b1;
         end
         @(negedge clk);
         for (int k = 0; k < 3; k++) eval(k, c);
         @(posedge clk);
         #1;
      end

      if (!did_async) chk("async_reset_reached", 32'd0, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
